// File: rtl/regfile_write_arbiter_if.sv
// Bus between the writeback sources and the register-file write arbiter.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int WORD_LENGTH = 32,
  parameter int BITS        = 5
);
  logic [NUM_REQ-1:0]             req_valid_i;
  logic [NUM_REQ*BITS-1:0]        req_addr_i;
  logic [NUM_REQ*WORD_LENGTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]             req_ready_o;
  logic                           stall_i;
  logic [BITS-1:0]                Write_Register_o;
  logic [WORD_LENGTH-1:0]         Write_Data_o;
  logic                           Reg_Write_o;
  logic [7:0]                     drop_count_o;
  logic                           conflict_o;

  // Writeback sources and register-file side
  modport master (
    output req_valid_i, req_addr_i, req_data_i, stall_i,
    input  req_ready_o, Write_Register_o, Write_Data_o, Reg_Write_o,
           drop_count_o, conflict_o
  );

  // Arbiter side
  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, stall_i,
    output req_ready_o, Write_Register_o, Write_Data_o, Reg_Write_o,
           drop_count_o, conflict_o
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among
// NUM_REQ writeback sources, with one registered write stage. Writes to r0
// are accepted and counted but never reach the register file.
module regfile_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WORD_LENGTH = 32,
  parameter int BITS        = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_write_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]       r_rr_ptr;
  logic                   r_reg_write;
  logic [BITS-1:0]        r_wr_addr;
  logic [WORD_LENGTH-1:0] r_wr_data;
  logic [7:0]             r_drop_cnt;
  logic                   r_conflict;

  logic                   w_found;
  logic [PTR_W-1:0]       w_win_idx;
  int                     w_idx;
  logic                   w_xfer;
  logic [NUM_REQ-1:0]     w_ready;
  logic [BITS-1:0]        w_win_addr;
  logic [WORD_LENGTH-1:0] w_win_data;
  logic                   w_conflict;

  // Search from the round-robin pointer for the first valid requester
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = (int'(r_rr_ptr) + i) % NUM_REQ;
      if (!w_found && bus.req_valid_i[w_idx]) begin
        w_found   = 1'b1;
        w_win_idx = w_idx[PTR_W-1:0];
      end
    end
  end

  // One-hot grant, suppressed by stall and while reset is asserted
  always_comb begin
    w_xfer  = w_found & ~bus.stall_i & reset;
    w_ready = '0;
    if (w_xfer) w_ready[w_win_idx] = 1'b1;
    w_win_addr = bus.req_addr_i[w_win_idx*BITS +: BITS];
    w_win_data = bus.req_data_i[w_win_idx*WORD_LENGTH +: WORD_LENGTH];
  end

  // Any two valid requests aiming at the same nonzero register
  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = i + 1; j < NUM_REQ; j++) begin
        if (bus.req_valid_i[i] && bus.req_valid_i[j] &&
            (bus.req_addr_i[i*BITS +: BITS] == bus.req_addr_i[j*BITS +: BITS]) &&
            (bus.req_addr_i[i*BITS +: BITS] != '0))
          w_conflict = 1'b1;
      end
    end
  end

  // Pointer advance, write stage, r0 drop counter and collision flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rr_ptr    <= '0;
      r_reg_write <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_drop_cnt  <= '0;
      r_conflict  <= 1'b0;
    end else begin
      r_conflict  <= w_conflict;
      r_reg_write <= 1'b0;
      if (w_xfer) begin
        r_rr_ptr <= (w_win_idx == LAST_IDX) ? '0 : w_win_idx + 1'b1;
        if (w_win_addr != '0) begin
          r_reg_write <= 1'b1;
          r_wr_addr   <= w_win_addr;
          r_wr_data   <= w_win_data;
        end else if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.req_ready_o      = w_ready;
  assign bus.Reg_Write_o      = r_reg_write;
  assign bus.Write_Register_o = r_wr_addr;
  assign bus.Write_Data_o     = r_wr_data;
  assign bus.drop_count_o     = r_drop_cnt;
  assign bus.conflict_o       = r_conflict;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  regfile_write_arbiter_if #(.NUM_REQ(4), .WORD_LENGTH(32), .BITS(5)) bus ();

  regfile_write_arbiter #(.NUM_REQ(4), .WORD_LENGTH(32), .BITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [4:0] a, input logic [31:0] d);
    bus.req_addr_i[k*5 +: 5]   = a;
    bus.req_data_i[k*32 +: 32] = d;
  endtask

  task automatic reset_pulse();
    bus.req_valid_i = '0;
    bus.stall_i     = 1'b0;
    reset           = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b0;
    bus.stall_i     = 1'b0;
    bus.req_valid_i = 4'b1111;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    for (int k = 0; k < 4; k++) set_req(k, 5'(k + 1), 32'h100 + k);

    // reset held with every request valid
    for (int c = 0; c < 3; c++) begin
      #1;
      check("rst_ready", 64'(bus.req_ready_o), 64'h0);
      tick();
      check("rst_regwrite", 64'(bus.Reg_Write_o), 64'h0);
      check("rst_drop", 64'(bus.drop_count_o), 64'h0);
      check("rst_waddr", 64'(bus.Write_Register_o), 64'h0);
      check("rst_conflict", 64'(bus.conflict_o), 64'h0);
    end

    // transfer, then reset at the following edge cancels the write
    reset = 1'b1;
    bus.req_valid_i = 4'b0001;
    set_req(0, 5'd3, 32'h0000_0011);
    #1;
    check("midrst_ready", 64'(bus.req_ready_o), 64'h1);
    tick();
    check("midrst_write", 64'(bus.Reg_Write_o), 64'h1);
    bus.req_valid_i = 4'b0000;
    reset = 1'b0;
    tick();
    check("midrst_cancel", 64'(bus.Reg_Write_o), 64'h0);
    check("midrst_addr", 64'(bus.Write_Register_o), 64'h0);
    reset = 1'b1;
    #1;

    // single requester 2
    bus.req_valid_i = 4'b0100;
    set_req(2, 5'd5, 32'hDEAD_BEEF);
    #1;
    check("t2_ready", 64'(bus.req_ready_o), 64'h4);
    tick();
    bus.req_valid_i = 4'b0000;
    check("t2_we", 64'(bus.Reg_Write_o), 64'h1);
    check("t2_addr", 64'(bus.Write_Register_o), 64'h5);
    check("t2_data", 64'(bus.Write_Data_o), 64'hDEAD_BEEF);
    tick();
    check("t2_we_off", 64'(bus.Reg_Write_o), 64'h0);
    check("t2_addr_hold", 64'(bus.Write_Register_o), 64'h5);

    // all four continuously valid: rotation 0,1,2,3,0
    reset_pulse();
    for (int k = 0; k < 4; k++) set_req(k, 5'(k + 1), 32'hA000_0000 + k);
    bus.req_valid_i = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t3_ready", 64'(bus.req_ready_o), 64'(4'b0001 << (c % 4)));
      tick();
      check("t3_we", 64'(bus.Reg_Write_o), 64'h1);
      check("t3_addr", 64'(bus.Write_Register_o), 64'((c % 4) + 1));
      check("t3_data", 64'(bus.Write_Data_o), 64'(32'hA000_0000 + (c % 4)));
    end
    bus.req_valid_i = 4'b0000;
    tick();
    check("t3_idle", 64'(bus.Reg_Write_o), 64'h0);

    // r0 writes from requester 1 are accepted and dropped
    reset_pulse();
    set_req(1, 5'd0, 32'h5555_5555);
    bus.req_valid_i = 4'b0010;
    for (int c = 1; c <= 300; c++) begin
      #1;
      if (c <= 3) check("t4_ready", 64'(bus.req_ready_o), 64'h2);
      tick();
      if (c <= 3) check("t4_we", 64'(bus.Reg_Write_o), 64'h0);
      if (c == 3) check("t4_drop3", 64'(bus.drop_count_o), 64'd3);
      if (c == 255) check("t4_drop255", 64'(bus.drop_count_o), 64'd255);
      if (c == 256) check("t4_sat", 64'(bus.drop_count_o), 64'd255);
    end
    check("t4_drop300", 64'(bus.drop_count_o), 64'd255);
    check("t4_addr_hold", 64'(bus.Write_Register_o), 64'h0);

    // stall holds off acceptance
    reset_pulse();
    set_req(0, 5'd9, 32'h1234_5678);
    bus.req_valid_i = 4'b0001;
    bus.stall_i     = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("t5_stall_ready", 64'(bus.req_ready_o), 64'h0);
      tick();
      check("t5_stall_we", 64'(bus.Reg_Write_o), 64'h0);
    end
    bus.stall_i = 1'b0;
    #1;
    check("t5_ready", 64'(bus.req_ready_o), 64'h1);
    tick();
    bus.req_valid_i = 4'b0000;
    check("t5_we", 64'(bus.Reg_Write_o), 64'h1);
    check("t5_addr", 64'(bus.Write_Register_o), 64'h9);
    check("t5_data", 64'(bus.Write_Data_o), 64'h1234_5678);

    // same-address collision between requesters 0 and 3
    reset_pulse();
    set_req(0, 5'd7, 32'h0000_00A0);
    set_req(3, 5'd7, 32'h0000_00B3);
    bus.req_valid_i = 4'b1001;
    #1;
    check("t6_ready0", 64'(bus.req_ready_o), 64'h1);
    tick();
    check("t6_conflict", 64'(bus.conflict_o), 64'h1);
    check("t6_data0", 64'(bus.Write_Data_o), 64'hA0);
    bus.req_valid_i = 4'b1000;
    #1;
    check("t6_ready3", 64'(bus.req_ready_o), 64'h8);
    tick();
    check("t6_data3", 64'(bus.Write_Data_o), 64'hB3);
    check("t6_noconflict", 64'(bus.conflict_o), 64'h0);
    bus.req_valid_i = 4'b0000;

    // collision flagged even while stalled; r0 pairs never flag
    bus.stall_i     = 1'b1;
    bus.req_valid_i = 4'b1001;
    tick();
    check("t6_stall_conflict", 64'(bus.conflict_o), 64'h1);
    check("t6_stall_we", 64'(bus.Reg_Write_o), 64'h0);
    set_req(0, 5'd0, 32'h0);
    set_req(3, 5'd0, 32'h0);
    tick();
    check("t6_r0_noconflict", 64'(bus.conflict_o), 64'h0);
    bus.stall_i     = 1'b0;
    bus.req_valid_i = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
